// File: rtl/tlul_pkg.sv
// TL-UL shared package: bus widths, A/D channel opcodes, host/device
// channel structs, plus the error-responder queue entry and default read data.
package tlul_pkg;

  localparam int TL_AW  = 32;        // address width
  localparam int TL_DW  = 32;        // data width
  localparam int TL_AIW = 8;         // source id width
  localparam int TL_DIW = 1;         // sink id width
  localparam int TL_DBW = TL_DW / 8; // byte mask width
  localparam int TL_SZW = 2;         // size field width

  typedef enum logic [2:0] {
    PutFullData    = 3'h0,
    PutPartialData = 3'h1,
    Get            = 3'h4
  } tl_a_op_e;

  typedef enum logic [2:0] {
    AccessAck     = 3'h0,
    AccessAckData = 3'h1
  } tl_d_op_e;

  typedef struct packed {
    logic                a_valid;
    tl_a_op_e            a_opcode;
    logic [2:0]          a_param;
    logic [TL_SZW-1:0]   a_size;
    logic [TL_AIW-1:0]   a_source;
    logic [TL_AW-1:0]    a_address;
    logic [TL_DBW-1:0]   a_mask;
    logic [TL_DW-1:0]    a_data;
    logic                d_ready;
  } tl_h2d_t;

  typedef struct packed {
    logic                d_valid;
    tl_d_op_e            d_opcode;
    logic [2:0]          d_param;
    logic [TL_SZW-1:0]   d_size;
    logic [TL_AIW-1:0]   d_source;
    logic [TL_DIW-1:0]   d_sink;
    logic [TL_DW-1:0]    d_data;
    logic                d_error;
    logic                a_ready;
  } tl_d2h_t;

  // Read data returned on Get responses unless the responder overrides it.
  localparam logic [TL_DW-1:0] ErrRspDataDefault = 32'hFFFF_FFFF;

  // Everything needed to build a response later; address/data are not kept.
  typedef struct packed {
    logic [TL_AIW-1:0] source;
    logic [TL_SZW-1:0] size;
    logic              is_get;
  } tl_err_entry_t;

endpackage

// File: rtl/tlul_err_fifo.sv
// Synchronous FIFO of error-response entries.
// Ports:
//   clk_i, rst_i        clock, synchronous active-high reset
//   wvalid/wready/wdata write side; push when wvalid & wready
//   rvalid/rready/rdata read side; rdata is the head entry, pop when rvalid & rready
//   depth               current occupancy (0..Depth)
// Handshake: a transfer happens on a side exactly in a cycle where valid and
// ready are both high at the clock edge; wready depends only on registered
// occupancy, so a pop in the same cycle never frees a slot for a push while full.
module tlul_err_fifo
  import tlul_pkg::*;
#(
  parameter int Depth = 2,
  localparam int CntW = $clog2(Depth + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          wvalid,
  output logic          wready,
  input  tl_err_entry_t wdata,
  output logic          rvalid,
  input  logic          rready,
  output tl_err_entry_t rdata,
  output logic [CntW-1:0] depth
);

  localparam int PtrW = (Depth > 1) ? $clog2(Depth) : 1;
  localparam logic [PtrW-1:0] LastPtr = PtrW'(Depth - 1);

  logic [PtrW-1:0] wptr;
  logic [PtrW-1:0] rptr;
  logic [CntW-1:0] count;
  tl_err_entry_t   mem [Depth];

  logic push;
  logic pop;

  // Pointers wrap at Depth, which need not be a power of two.
  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrW'(1);
  endfunction

  assign wready = (count != CntW'(Depth));
  assign rvalid = (count != '0);
  assign push   = wvalid & wready;
  assign pop    = rvalid & rready;
  assign rdata  = mem[rptr];
  assign depth  = count;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= ptr_inc(wptr);
      if (pop)  rptr <= ptr_inc(rptr);
      case ({push, pop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while count > 0.
  always_ff @(posedge clk_i) begin
    if (push) mem[wptr] <= wdata;
  end

endmodule

// File: rtl/tlul_err_resp_q.sv
// TL-UL error responder with an in-order response queue. Every accepted
// request gets exactly one response built from the queued entry; the
// response carries a configurable d_error flag and Get read-data pattern.
// Ports:
//   clk_i, rst_i  clock, synchronous active-high reset
//   tl_h_i        TL-UL host request (A channel + d_ready)
//   tl_h_o        TL-UL device response (D channel + a_ready)
//   cnt_clr_i     clears err_cnt_o (a same-cycle accept makes it 1)
//   err_cnt_o     saturating count of accepted requests
//   err_addr_o    a_address of the most recently accepted request
module tlul_err_resp_q
  import tlul_pkg::*;
#(
  parameter int              Depth     = 2,
  parameter bit              ErrEnable = 1'b1,
  parameter logic [TL_DW-1:0] RspData  = ErrRspDataDefault,
  parameter int              CntWidth  = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  tl_h2d_t             tl_h_i,
  output tl_d2h_t             tl_h_o,
  input  logic                cnt_clr_i,
  output logic [CntWidth-1:0] err_cnt_o,
  output logic [TL_AW-1:0]    err_addr_o
);

  localparam int OccW = $clog2(Depth + 1);

  tl_err_entry_t   wr_entry;
  tl_err_entry_t   head;
  logic            fifo_wready;
  logic            fifo_rvalid;
  logic [OccW-1:0] fifo_depth;
  logic            push;

  // Occupancy, mask, data and param are not needed to form a response.
  logic unused_sigs;
  assign unused_sigs = ^{fifo_depth, tl_h_i.a_mask, tl_h_i.a_data, tl_h_i.a_param};

  // Any opcode other than Get (including unknown encodings) is acked as a write.
  assign wr_entry.source = tl_h_i.a_source;
  assign wr_entry.size   = tl_h_i.a_size;
  assign wr_entry.is_get = (tl_h_i.a_opcode == Get);

  assign push = tl_h_i.a_valid & fifo_wready;

  tlul_err_fifo #(
    .Depth (Depth)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .wvalid (tl_h_i.a_valid),
    .wready (fifo_wready),
    .wdata  (wr_entry),
    .rvalid (fifo_rvalid),
    .rready (tl_h_i.d_ready),
    .rdata  (head),
    .depth  (fifo_depth)
  );

  // Response fields come only from the registered head entry, so they hold
  // steady while d_valid is high and d_ready is low.
  always_comb begin
    tl_h_o          = '0;
    tl_h_o.a_ready  = fifo_wready;
    tl_h_o.d_valid  = fifo_rvalid;
    tl_h_o.d_opcode = head.is_get ? AccessAckData : AccessAck;
    tl_h_o.d_data   = head.is_get ? RspData : '0;
    tl_h_o.d_error  = ErrEnable;
    tl_h_o.d_source = head.source;
    tl_h_o.d_size   = head.size;
    tl_h_o.d_param  = '0;
    tl_h_o.d_sink   = '0;
  end

  // Clear combined with an accept counts that accept, giving 1.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      err_cnt_o  <= '0;
      err_addr_o <= '0;
    end else begin
      if (push) err_addr_o <= tl_h_i.a_address;
      if (cnt_clr_i && push) begin
        err_cnt_o <= CntWidth'(1);
      end else if (cnt_clr_i) begin
        err_cnt_o <= '0;
      end else if (push && (err_cnt_o != '1)) begin
        err_cnt_o <= err_cnt_o + CntWidth'(1);
      end
    end
  end

endmodule
